// File: rtl/display_scan_mux_pkg.sv
// Shared constants for the time-of-day display scanner.
//   - default digit count and divider ratios for the board clock
//   - named digit positions (digit 0 is the rightmost, seconds units)
//   - a small BCD validity helper used by the blanking logic
package display_scan_mux_pkg;

  localparam int DEF_NUM_DIGITS = 6;
  localparam int DEF_SCAN_DIV   = 50000;  // clocks per digit slot
  localparam int DEF_BLINK_DIV  = 250;    // slot ticks per blink half-period

  // Digit positions for an HH:MM:SS layout
  localparam int SEC_U = 0;
  localparam int SEC_T = 1;
  localparam int MIN_U = 2;
  localparam int MIN_T = 3;
  localparam int HR_U  = 4;
  localparam int HR_T  = 5;

  // True for codes the seven-segment decoder can render (0-9)
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/display_scan_mux_tick_divider.sv
// tick_divider: free-running modulo-DIV counter with a single-cycle tick.
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   enable in  counter advances only while high; holds otherwise
//   tick   out combinational, high on the enabled cycle where the count
//              is at DIV-1 (i.e. the edge on which it wraps to 0)
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // With DIV=1 the count sits at 0 and tick follows enable directly.
  assign tick = enable && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes NUM_DIGITS BCD digits onto one shared
// seven-segment decoder.
//   clk        in  system clock
//   reset      in  synchronous, active-high
//   enable     in  1 = scanning; 0 = counters hold, display dark
//   digits     in  packed BCD, digit i at [4i+3:4i]
//   blink_mask in  per-digit blink enable (time-set mode)
//   blank_lead in  suppress a zero in the most significant digit
//   number     out registered BCD nibble for the decoder (always 0-9)
//   digit_sel  out registered one-hot digit enable, all-zero when blanked
//   slot       out registered current digit index
//   scan_tick  out registered one-cycle pulse on each slot advance
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int BLINK_DIV  = DEF_BLINK_DIV,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lead,
  output logic [3:0]              number,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [2:0]              slot,
  output logic                    scan_tick
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_DIGITS - 1);

  logic       tick;
  logic       blink_wrap;
  logic       blink_phase;
  logic       blink_phase_next;
  logic [2:0] slot_next;
  logic [3:0] cur_digit;
  logic       cur_mask;
  logic       blanked;

  // Slot prescaler
  tick_divider #(.DIV(SCAN_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // Blink divider counts slot ticks, so it freezes along with the scan
  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk    (clk),
    .reset  (reset),
    .enable (tick),
    .tick   (blink_wrap)
  );

  always_comb begin
    slot_next = slot;
    if (tick) slot_next = (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
  end

  // The slot being entered sees the phase that takes effect on the same edge
  assign blink_phase_next = blink_phase ^ blink_wrap;

  // Select the digit and mask bit for the upcoming slot
  always_comb begin
    cur_digit = '0;
    cur_mask  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_next == 3'(i)) begin
        cur_digit = digits[4*i +: 4];
        cur_mask  = blink_mask[i];
      end
    end
  end

  assign blanked = (blink_phase_next && cur_mask)
                || !is_bcd(cur_digit)
                || (blank_lead && (slot_next == LAST_SLOT) && (cur_digit == 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      slot        <= '0;
      blink_phase <= 1'b0;
      number      <= '0;
      digit_sel   <= '0;
      scan_tick   <= 1'b0;
    end else if (enable) begin
      slot        <= slot_next;
      blink_phase <= blink_phase_next;
      scan_tick   <= tick;
      if (blanked) begin
        number    <= '0;
        digit_sel <= '0;
      end else begin
        number    <= cur_digit;
        digit_sel <= NUM_DIGITS'(1) << slot_next;
      end
    end else begin
      // Dark while paused; counters hold inside the dividers and slot above
      number    <= '0;
      digit_sel <= '0;
      scan_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

  localparam int ND  = 6;
  localparam int SDA = 4;
  localparam int BDA = 3;
  localparam int SDB = 1;
  localparam int BDB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, blank_lead;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] blink_mask;

  logic [3:0]    num_a, num_b;
  logic [ND-1:0] sel_a, sel_b;
  logic [2:0]    slot_a, slot_b;
  logic          tick_a, tick_b;

  display_scan_mux #(.SCAN_DIV(SDA), .BLINK_DIV(BDA), .NUM_DIGITS(ND)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits),
    .blink_mask(blink_mask), .blank_lead(blank_lead),
    .number(num_a), .digit_sel(sel_a), .slot(slot_a), .scan_tick(tick_a));

  display_scan_mux #(.SCAN_DIV(SDB), .BLINK_DIV(BDB), .NUM_DIGITS(ND)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits),
    .blink_mask(blink_mask), .blank_lead(blank_lead),
    .number(num_b), .digit_sel(sel_b), .slot(slot_b), .scan_tick(tick_b));

  typedef struct packed {
    logic [3:0]    num;
    logic [ND-1:0] sel;
    logic [2:0]    slot;
    logic          tick;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   ka = 0, kb = 0;  // enabled edges since reset, per instance
  exp_t ea, eb;

  // Behavioural model: after k enabled edges, k/sd slot ticks have occurred;
  // the slot is that count mod ND and the blink phase flips every bd ticks.
  function automatic exp_t model(input int k, input int sd, input int bd, input bit live);
    exp_t e;
    int t, s, d;
    bit phase, blanked;
    t = k / sd;
    s = t % ND;
    phase = ((t / bd) % 2) == 1;
    e = '0;
    e.slot = 3'(s);
    if (live) begin
      d = int'((digits >> (4 * s)) & 24'hF);
      blanked = (phase && blink_mask[s]) || (d > 9) || (blank_lead && s == ND - 1 && d == 0);
      e.tick = (k % sd) == 0;
      if (!blanked) begin
        e.num = 4'(d);
        e.sel = ND'(1 << s);
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge, advance the model, then compare on the falling edge
  task automatic step(input logic r, input logic en);
    reset  = r;
    enable = en;
    if (r) begin
      ka = 0; kb = 0;
    end else if (en) begin
      ka++; kb++;
    end
    ea = model(ka, SDA, BDA, !r && en);
    eb = model(kb, SDB, BDB, !r && en);
    @(posedge clk);
    @(negedge clk);
    check("a_num",  32'(num_a),  32'(ea.num));
    check("a_sel",  32'(sel_a),  32'(ea.sel));
    check("a_slot", 32'(slot_a), 32'(ea.slot));
    check("a_tick", 32'(tick_a), 32'(ea.tick));
    check("b_num",  32'(num_b),  32'(eb.num));
    check("b_sel",  32'(sel_b),  32'(eb.sel));
    check("b_slot", 32'(slot_b), 32'(eb.slot));
    check("b_tick", 32'(tick_b), 32'(eb.tick));
    check("a_onehot0", 32'($countones(sel_a) <= 1), 32'd1);
    check("b_onehot0", 32'($countones(sel_b) <= 1), 32'd1);
    check("a_num_le9", 32'(num_a <= 4'd9), 32'd1);
    check("b_num_le9", 32'(num_b <= 4'd9), 32'd1);
  endtask

  task automatic restart();
    step(1'b1, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [3:0] nib;
    reset = 1'b1; enable = 1'b0; blank_lead = 1'b0;
    digits = 24'h123456; blink_mask = '0;

    // Reset state and rotation (A: SCAN_DIV=4)
    restart();
    restart();
    check("rst_sel",  32'(sel_a), 32'd0);
    check("rst_num",  32'(num_a), 32'd0);
    check("rst_slot", 32'(slot_a), 32'd0);
    check("rst_tick", 32'(tick_a), 32'd0);
    step(1'b0, 1'b1);
    check("first_sel", 32'(sel_a), 32'b000001);
    check("first_num", 32'(num_a), 32'd6);
    pulses = 0;
    for (int i = 2; i <= 24; i++) begin
      step(1'b0, 1'b1);
      if (tick_a) pulses++;
      if (i == 8)  check("rot_slot2_num", 32'(num_a), 32'd4);
      if (i == 20) check("rot_slot5_num", 32'(num_a), 32'd1);
    end
    check("rot_wrap_sel", 32'(sel_a), 32'b000001);
    check("rot_wrap_num", 32'(num_a), 32'd6);
    check("rot_pulses", 32'(pulses), 32'd6);

    // Blink (B: SCAN_DIV=1, BLINK_DIV=2)
    digits = 24'h000099; blink_mask = 6'b000011;
    restart();
    step(1'b0, 1'b1);
    check("blink_s1_sel", 32'(sel_b), 32'b000010);
    check("blink_s1_num", 32'(num_b), 32'd9);
    step(1'b0, 1'b1);
    check("blink_s2_sel", 32'(sel_b), 32'b000100);
    for (int i = 3; i <= 6; i++) step(1'b0, 1'b1);
    check("blink_off_sel", 32'(sel_b), 32'd0);
    check("blink_off_num", 32'(num_b), 32'd0);

    // Leading zero
    digits = 24'h095959; blink_mask = '0; blank_lead = 1'b1;
    restart();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("lead_blank_sel", 32'(sel_b), 32'd0);
    blank_lead = 1'b0;
    restart();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("lead_show_sel", 32'(sel_b), 32'b100000);
    check("lead_show_num", 32'(num_b), 32'd0);
    digits = 24'h195959; blank_lead = 1'b1;
    restart();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("lead_one_num", 32'(num_b), 32'd1);

    // Invalid BCD in digit 2
    digits = 24'h123C56; blank_lead = 1'b0;
    restart();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("bad_bcd_sel", 32'(sel_b), 32'd0);
    check("bad_bcd_num", 32'(num_b), 32'd0);

    // Pause mid-slot at slot 3, pcnt 2 on A
    digits = 24'h123456;
    restart();
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
    check("pause_pre_slot", 32'(slot_a), 32'd3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("pause_sel",  32'(sel_a), 32'd0);
    check("pause_slot", 32'(slot_a), 32'd3);
    step(1'b0, 1'b1);
    check("resume1_slot", 32'(slot_a), 32'd3);
    check("resume1_tick", 32'(tick_a), 32'd0);
    check("resume1_num",  32'(num_a), 32'd3);
    step(1'b0, 1'b1);
    check("resume2_slot", 32'(slot_a), 32'd4);
    check("resume2_tick", 32'(tick_a), 32'd1);
    check("resume2_num",  32'(num_a), 32'd2);

    // Reset mid-operation at slot 4 with blink phase 1 on A
    blink_mask = 6'h3F;
    restart();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
    check("midrst_pre_slot", 32'(slot_a), 32'd4);
    check("midrst_pre_sel",  32'(sel_a), 32'd0);
    step(1'b1, 1'b1);
    check("midrst_sel",  32'(sel_a), 32'd0);
    check("midrst_slot", 32'(slot_a), 32'd0);
    step(1'b0, 1'b1);
    check("midrst_first_sel", 32'(sel_a), 32'b000001);
    check("midrst_first_num", 32'(num_a), 32'd6);

    // Randomized traffic
    restart();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < ND; j++) begin
          nib = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
          digits[4*j +: 4] = nib;
        end
      end
      if ($urandom_range(0, 15) == 0) blink_mask = ND'($urandom) & ND'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lead = 1'($urandom);
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 9) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
